// File: rtl/alu_flag_unit.sv
// EX-stage condition-flag register with per-opcode update masks, same-cycle
// flag bypass for the ID-stage branch decision, and a saturation-event counter.
module alu_flag_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  opcode,
    input  logic [15:0] alu_out,
    input  logic        alu_v,
    input  logic        psa_ovfl,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic        clr_cnt,
    output logic [2:0]  flags,
    output logic        br_taken,
    output logic [15:0] sat_cnt
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } opcode_e;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GTE = 3'b100,
        CC_LTE = 3'b101,
        CC_OV  = 3'b110,
        CC_UNC = 3'b111
    } cond_e;

    logic       commit;
    logic       write_all;
    logic       write_z;
    logic       is_addsub;
    logic       is_paddsb;
    logic       sat_event;
    logic [2:0] flags_next;
    logic       e_z;
    logic       e_v;
    logic       e_n;
    logic       cond;

    assign commit = ex_valid & ~stall & ~flush;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        write_all = 1'b0;
        write_z   = 1'b0;
        is_addsub = 1'b0;
        is_paddsb = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                write_all = 1'b1;
                is_addsub = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: write_z = 1'b1;
            OP_PADDSB: is_paddsb = 1'b1;
            default: ;
        endcase
    end

    // Flag order is {Z, V, N}; a masked-off flag simply carries its registered value.
    always_comb begin
        flags_next = flags;
        if (commit && write_all) begin
            flags_next = {(alu_out == 16'h0000), alu_v, alu_out[15]};
        end else if (commit && write_z) begin
            flags_next[2] = (alu_out == 16'h0000);
        end
    end

    // The branch sees the flags this cycle's commit will write, not the stale ones.
    assign e_z = flags_next[2];
    assign e_v = flags_next[1];
    assign e_n = flags_next[0];

    always_comb begin
        cond = 1'b1;
        case (br_cond)
            CC_NE:  cond = ~e_z;
            CC_EQ:  cond = e_z;
            CC_GT:  cond = ~e_z & ~e_n;
            CC_LT:  cond = e_n;
            CC_GTE: cond = e_z | (~e_z & ~e_n);
            CC_LTE: cond = e_n | e_z;
            CC_OV:  cond = e_v;
            CC_UNC: cond = 1'b1;
            default: cond = 1'b1;
        endcase
    end

    assign br_taken  = br_valid & cond;
    assign sat_event = commit & ((is_addsub & alu_v) | (is_paddsb & psa_ovfl));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 3'b000;
        end else begin
            flags <= flags_next;
        end
    end

    // The clear wins over a same-cycle event; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 16'h0000;
        end else if (clr_cnt) begin
            sat_cnt <= 16'h0000;
        end else if (sat_event && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed self-checking bench for alu_flag_unit: reset, flag masks, bypass,
// stall/flush, counter saturation and clear, and a full branch-condition sweep.
module tb_alu_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        stall;
    logic        flush;
    logic [3:0]  opcode;
    logic [15:0] alu_out;
    logic        alu_v;
    logic        psa_ovfl;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        clr_cnt;
    logic [2:0]  flags;
    logic        br_taken;
    logic [15:0] sat_cnt;

    int checks;
    int failures;
    int exp_cnt;

    alu_flag_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .stall    (stall),
        .flush    (flush),
        .opcode   (opcode),
        .alu_out  (alu_out),
        .alu_v    (alu_v),
        .psa_ovfl (psa_ovfl),
        .br_valid (br_valid),
        .br_cond  (br_cond),
        .clr_cnt  (clr_cnt),
        .flags    (flags),
        .br_taken (br_taken),
        .sat_cnt  (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, well clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        opcode   = 4'b1000;
        alu_out  = 16'h0000;
        alu_v    = 1'b0;
        psa_ovfl = 1'b0;
        br_valid = 1'b0;
        br_cond  = 3'b000;
        clr_cnt  = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] res, input logic v, input logic p);
        ex_valid = 1'b1;
        opcode   = op;
        alu_out  = res;
        alu_v    = v;
        psa_ovfl = p;
    endtask

    task automatic chk_flags(input string name, input logic [2:0] exp);
        checks++;
        if (flags !== exp) begin
            failures++;
            $display("FAIL %s: flags=%b expected=%b", name, flags, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
        checks++;
        if (sat_cnt !== exp_cnt[15:0]) begin
            failures++;
            $display("FAIL %s: sat_cnt=%h expected=%h", name, sat_cnt, exp_cnt[15:0]);
        end
    endtask

    task automatic chk_br(input string name, input logic exp);
        checks++;
        if (br_taken !== exp) begin
            failures++;
            $display("FAIL %s: br_taken=%b expected=%b (cond=%b flags=%b)", name, br_taken, exp, br_cond, flags);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] c, input logic z, input logic v, input logic n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        exp_cnt = 0;
        chk_flags("reset_flags", 3'b000);
        chk_cnt("reset_cnt");
        br_valid = 1'b0;
        br_cond  = 3'b111;
        #1;
        chk_br("reset_br_invalid", 1'b0);
        br_valid = 1'b1;
        br_cond  = 3'b000;
        #1;
        chk_br("reset_br_ne", 1'b1);
        br_cond = 3'b001;
        #1;
        chk_br("reset_br_eq", 1'b0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_commit();
        issue(4'b0000, 16'h0000, 1'b1, 1'b0);
        tick();
        idle();
        exp_cnt++;
        chk_flags("add_zero_ovf", 3'b110);
        chk_cnt("add_zero_ovf_cnt");
    endtask

    task automatic test_masks();
        issue(4'b0000, 16'h8000, 1'b1, 1'b0);
        tick();
        exp_cnt++;
        issue(4'b0010, 16'h0000, 1'b0, 1'b0);
        tick();
        chk_flags("preset_111", 3'b111);
        issue(4'b0010, 16'h0005, 1'b1, 1'b1);
        tick();
        chk_flags("xor_z_only", 3'b011);
        issue(4'b0111, 16'h0000, 1'b0, 1'b1);
        tick();
        exp_cnt++;
        chk_flags("paddsb_no_flags", 3'b011);
        chk_cnt("paddsb_event");
        issue(4'b0011, 16'h0000, 1'b1, 1'b1);
        tick();
        chk_flags("red_no_flags", 3'b011);
        chk_cnt("red_no_event");
        issue(4'b1010, 16'h0000, 1'b1, 1'b1);
        tick();
        chk_flags("nonalu_no_flags", 3'b011);
        chk_cnt("nonalu_no_event");
        issue(4'b0101, 16'h0000, 1'b1, 1'b1);
        tick();
        chk_flags("sra_z_only", 3'b111);
        chk_cnt("sra_no_event");
        idle();
    endtask

    task automatic test_bypass();
        issue(4'b0000, 16'h0001, 1'b0, 1'b0);
        tick();
        chk_flags("bypass_pre", 3'b000);
        issue(4'b0001, 16'h8000, 1'b0, 1'b0);
        br_valid = 1'b1;
        br_cond  = 3'b011;
        flush    = 1'b1;
        #1;
        chk_br("flush_no_bypass", 1'b0);
        tick();
        chk_flags("flush_no_commit", 3'b000);
        flush = 1'b0;
        #1;
        chk_br("bypass_lt", 1'b1);
        tick();
        chk_flags("sub_neg", 3'b001);
        idle();
    endtask

    task automatic test_stall();
        issue(4'b0000, 16'h0000, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flags("stall_hold", 3'b001);
            chk_cnt("stall_cnt_hold");
        end
        flush = 1'b1;
        tick();
        chk_flags("stall_flush_hold", 3'b001);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        exp_cnt++;
        chk_flags("stall_release", 3'b110);
        chk_cnt("stall_release_cnt");
        idle();
    endtask

    task automatic test_saturation();
        int n;
        n = 16'hFFFE - exp_cnt;
        issue(4'b0000, 16'h0000, 1'b1, 1'b0);
        repeat (n) tick();
        exp_cnt = 16'hFFFE;
        chk_cnt("preload_fffe");
        issue(4'b0111, 16'h1234, 1'b0, 1'b1);
        tick();
        exp_cnt = 16'hFFFF;
        chk_cnt("sat_reach");
        tick();
        chk_cnt("sat_hold_1");
        tick();
        chk_cnt("sat_hold_2");
        clr_cnt = 1'b1;
        tick();
        exp_cnt = 0;
        chk_cnt("clr_beats_event");
        clr_cnt = 1'b0;
        tick();
        exp_cnt = 1;
        chk_cnt("count_after_clr");
        idle();
    endtask

    task automatic test_sweep();
        logic z;
        logic v;
        logic n;
        for (int f = 0; f < 8; f++) begin
            z = f[2];
            v = f[1];
            n = f[0];
            if (f == 4) begin
                rst_n = 1'b0;
                #1;
                chk_flags("sweep_reset_async", 3'b000);
                exp_cnt = 0;
                chk_cnt("sweep_reset_cnt");
                tick();
                rst_n = 1'b1;
            end
            issue(4'b0000, n ? 16'h8000 : 16'h0001, v, 1'b0);
            tick();
            issue(4'b0110, z ? 16'h0000 : 16'h0100, 1'b0, 1'b0);
            tick();
            idle();
            chk_flags("sweep_setup", {z, v, n});
            br_valid = 1'b1;
            for (int c = 0; c < 8; c++) begin
                br_cond = c[2:0];
                #1;
                chk_br("sweep_cond", ref_cond(c[2:0], z, v, n));
            end
            br_valid = 1'b0;
            #1;
            chk_br("sweep_br_invalid", 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        rst_n    = 1'b1;
        idle();
        #3;
        test_reset();
        test_add_commit();
        test_masks();
        test_bypass();
        test_stall();
        test_saturation();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Registered condition-flag unit for the EX stage, directly downstream of the ALU and its packed saturating adder. It captures Z/V/N from committed ALU results under per-opcode update masks, and honours pipeline stall and flush. It evaluates the 3-bit branch condition for the branch in ID, bypassing flags being written in the same cycle. It also keeps a saturating debug counter of saturation events (ADD/SUB overflow, PADDSB nibble overflow).

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- stall  in  1  EX stage held this cycle; no commit
- flush  in  1  EX instruction squashed this cycle; no commit
- opcode  in  4  EX instruction opcode
- alu_out  in  16  ALU result of the EX instruction
- alu_v  in  1  signed overflow from ADD/SUB
- psa_ovfl  in  1  any-nibble overflow flag from the packed adder (PADDSB)
- br_valid  in  1  ID stage holds a conditional branch (B/BR)
- br_cond  in  3  branch condition code
- clr_cnt  in  1  synchronous clear of sat_cnt
- flags  out  3  registered {Z, V, N}
- br_taken  out  1  combinational branch decision
- sat_cnt  out  16  saturating count of committed saturation events

## Operation
- commit = ex_valid & ~stall & ~flush. Without commit, no state changes except the sat_cnt clear.
- Opcodes: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111; 1000–1111 are non-ALU.
- Candidate flags: Zc = (alu_out == 16'h0000), Nc = alu_out[15], Vc = alu_v.
- Update masks on commit:
  - ADD, SUB: Z, V and N all written.
  - XOR, SLL, SRA, ROR: Z written only; V and N hold.
  - RED, PADDSB, all opcodes ≥ 1000: no flag written.
- Effective flags (eZ, eV, eN): the next-state flag values when commit is set and the opcode writes flags, otherwise the registered flags. This is same-cycle bypass for the branch in ID.
- br_taken = br_valid & cond, where cond is:
  - 000 NE: ~eZ
  - 001 EQ: eZ
  - 010 GT: ~eZ & ~eN
  - 011 LT: eN
  - 100 GTE: eZ | (~eZ & ~eN)
  - 101 LTE: eN | eZ
  - 110 OV: eV
  - 111 unconditional: 1
- Saturation event: commit & ((op ∈ {ADD, SUB} & alu_v) | (op == PADDSB & psa_ovfl)).
- sat_cnt update priority:
  1. clr_cnt: clear to 0.
  2. Otherwise, on an event: increment; holds at 16'hFFFF, never wraps.
- psa_ovfl is ignored for every opcode except PADDSB. alu_v is ignored except for ADD and SUB.

## Timing
- Reset (rst_n low, asynchronous): flags = 3'b000, sat_cnt = 16'h0000. Both take effect immediately, with no clock required.
- br_taken is combinational. It is 0 whenever br_valid = 0, and it follows the reset flag values while in reset (e.g. NE is taken, EQ is not).
- flags and sat_cnt update at the rising edge following a commit cycle. Latency is 1 cycle to flags; the bypass gives 0-cycle visibility to br_taken.
- stall and flush asserted together: no commit, the same as either alone.
- flush overrides the bypass: a squashed instruction never influences br_taken.
- Reset deasserted mid-stream: the first commit after release writes from reset values; there is no partial state.
- clr_cnt together with an event in the same cycle: the result is 0; the event is lost.

## Test plan
- Reset, then ADD commit with alu_out=16'h0000, alu_v=1 -> flags={Z=1,V=1,N=0} next cycle; sat_cnt=1.
- flags={1,1,1}, XOR commit with alu_out=16'h0005 -> flags={0,1,1}. Then PADDSB commit with psa_ovfl=1 -> flags unchanged; sat_cnt increments.
- SUB commit with alu_out=16'h8000 in the same cycle as br_valid=1, br_cond=011 -> br_taken=1 via bypass. The same stimulus with flush=1 -> br_taken uses the old flags.
- ADD with alu_out=16'h0000 and stall=1, held for 3 cycles -> flags unchanged throughout. Drop stall -> flags update the next edge.
- Preload sat_cnt to 16'hFFFE, then 3 PADDSB overflow commits -> 16'hFFFF, stays there. Then clr_cnt together with an event -> 16'h0000.
- Sweep all 8 br_cond values over all 8 flag combinations -> br_taken matches the condition list; rst_n pulsed low mid-sweep -> flags=000 immediately.
